// File: rtl/oh_rseq_pkg.sv
// Shared definitions for the oh_rseq reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding and default parameter values.
package oh_rseq_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_DELAY     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_DELAY = 16;
    localparam int unsigned DEF_CW    = 8;
    localparam int unsigned DEF_TW    = 16;

endpackage

// File: rtl/oh_rseq_timer.sv
// Loadable saturating up-counter with clear and a registered terminal-count flag.
// Latency: o_tc reflects the count held after each edge (no input-to-output path).
// Backpressure: none; the counter holds at MAX instead of wrapping.
// Ports: i_clk, i_rst (sync, active high), i_clr (highest priority), i_load/i_load_val,
//        i_en (count enable), o_tc (count == MAX).
module oh_rseq_timer #(
    parameter int unsigned    W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic         r_tc;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_load) begin
            w_cnt_nxt = i_load_val;
        end else if (i_en && (r_cnt != MAX)) begin
            w_cnt_nxt = r_cnt + W'(1);
        end
    end

    // The flag is computed from the next count so it is valid in the same
    // cycle the count reaches MAX, while still coming straight off a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_tc  <= (MAX == '0);
        end else begin
            r_cnt <= w_cnt_nxt;
            r_tc  <= (w_cnt_nxt == MAX);
        end
    end

    assign o_tc = r_tc;

endmodule

// File: rtl/oh_rseq.sv
// Reset sequencer: after lock, releases N active-low domain resets one at a time, DELAY cycles apart.
// Latency: nrst_out[k] rises DELAY*(k+1) edges after lock is sampled; lock loss/soft_rst clear in 1 cycle.
// Backpressure: none; lock loss or soft_rst drops all released resets together and restarts the sequence.
// Ports: clk, rst (sync, active high), lock, soft_rst -> nrst_out[N-1:0], busy, done, err.
// Optional macro OH_RSEQ_WDOG_EN adds a TW-bit lock-timeout watchdog driving a sticky err;
// without it err is constant 0.
module oh_rseq
    import oh_rseq_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned DELAY = DEF_DELAY,
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned TW    = DEF_TW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lock,
    input  logic         soft_rst,
    output logic [N-1:0] nrst_out,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    if ((N < 1) || (DELAY < 1) || (TW < 1) ||
        (64'(DELAY - 1) >= (64'(1) << CW))) begin : g_bad_param
        $error("oh_rseq: illegal parameter combination");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [N-1:0]    r_nrst;
    logic [N-1:0]    w_nrst_nxt;
    logic            r_busy;
    logic            r_done;
    logic            w_cnt_clr;
    logic            w_cnt_en;
    logic            w_cnt_tc;

    oh_rseq_timer #(
        .W   (CW),
        .MAX (CW'(DELAY - 1))
    ) u_dly (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (w_cnt_clr),
        .i_en       (w_cnt_en),
        .i_load     (1'b0),
        .i_load_val ({CW{1'b0}}),
        .o_tc       (w_cnt_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_nrst_nxt  = r_nrst;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_clr   = 1'b1;
            end
            S_WAIT_LOCK: begin
                if (soft_rst) begin
                    w_idx_nxt  = '0;
                    w_nrst_nxt = '0;
                    w_cnt_clr  = 1'b1;
                end else if (lock) begin
                    w_state_nxt = S_DELAY;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_DELAY, S_DONE: begin
                if (soft_rst || !lock) begin
                    // All released domains fall together; never one at a time.
                    w_state_nxt = S_WAIT_LOCK;
                    w_idx_nxt   = '0;
                    w_nrst_nxt  = '0;
                    w_cnt_clr   = 1'b1;
                end else if (r_state == S_DELAY) begin
                    if (w_cnt_tc) begin
                        // Shift a one in at bit 0 so the released bits stay contiguous.
                        w_nrst_nxt = (r_nrst << 1) | N'(1);
                        w_cnt_clr  = 1'b1;
                        if (r_idx == IW'(N - 1)) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_nrst  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_nrst  <= w_nrst_nxt;
            r_busy  <= (w_state_nxt == S_WAIT_LOCK) || (w_state_nxt == S_DELAY);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign nrst_out = r_nrst;
    assign busy     = r_busy;
    assign done     = r_done;

`ifdef OH_RSEQ_WDOG_EN
    logic w_wd_tc;
    logic r_err;

    // Counts only while stuck waiting for lock; any exit from WAIT_LOCK clears it.
    oh_rseq_timer #(
        .W   (TW),
        .MAX ({TW{1'b1}})
    ) u_wdog (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (r_state != S_WAIT_LOCK),
        .i_en       ((r_state == S_WAIT_LOCK) && !lock),
        .i_load     (1'b0),
        .i_load_val ({TW{1'b0}}),
        .o_tc       (w_wd_tc)
    );

    // Sticky until rst; soft_rst deliberately leaves it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_wd_tc) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_oh_rseq.sv
// Directed bench for oh_rseq: default instance (N=4, DELAY=16) plus a DELAY=1 instance on shared inputs.
module tb_oh_rseq;

`ifdef OH_RSEQ_WDOG_EN
    localparam int unsigned TW_TB = 4;
    localparam logic        ERR_STUCK = 1'b1;
`else
    localparam int unsigned TW_TB = 16;
    localparam logic        ERR_STUCK = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       lock;
    logic       soft_rst;
    logic [3:0] nrst_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] nrst_out1;
    logic       busy1;
    logic       done1;
    logic       err1;

    int n_chk  = 0;
    int n_pass = 0;

    oh_rseq #(.N(4), .DELAY(16), .CW(8), .TW(TW_TB)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .lock     (lock),
        .soft_rst (soft_rst),
        .nrst_out (nrst_out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    oh_rseq #(.N(4), .DELAY(1), .CW(8), .TW(TW_TB)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .lock     (lock),
        .soft_rst (soft_rst),
        .nrst_out (nrst_out1),
        .busy     (busy1),
        .done     (done1),
        .err      (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs 64 cycles after E0 and checks the staircase of releases.
    task automatic run_sequence(input string tag);
        for (int k = 1; k <= 64; k++) begin
            tick();
            if ((k % 16) == 15) chk({tag, "_pre"}, nrst_out, (32'd1 << (k / 16)) - 1);
            if ((k % 16) == 0)  chk({tag, "_rel"}, nrst_out, (32'd1 << (k / 16)) - 1);
            if (k == 63) chk({tag, "_done63"}, done, 0);
            if (k == 64) begin
                chk({tag, "_done64"}, done, 1);
                chk({tag, "_busy64"}, busy, 0);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        lock     = 1'b1;
        soft_rst = 1'b0;
        tick();
        tick();
        tick();

        // Reset state
        chk("rst_nrst", nrst_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  err, 0);
        chk("rst_nrst1", nrst_out1, 0);

        // Release with lock already high: IDLE edge, then E0
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 1);
        chk("idle_nrst", nrst_out, 0);
        tick();                                  // E0
        chk("e0_nrst", nrst_out, 0);
        chk("e0_busy", busy, 1);
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k <= 4) chk("d1_rel", nrst_out1, (32'd1 << k) - 1);
            if (k == 3) chk("d1_done3", done1, 0);
            if (k == 4) chk("d1_done4", done1, 1);
            if ((k % 16) == 15) chk("seq1_pre", nrst_out, (32'd1 << (k / 16)) - 1);
            if ((k % 16) == 0)  chk("seq1_rel", nrst_out, (32'd1 << (k / 16)) - 1);
            if (k == 64) begin
                chk("seq1_done", done, 1);
                chk("seq1_busy", busy, 0);
            end
        end

        // soft_rst in DONE
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("soft_nrst", nrst_out, 0);
        chk("soft_done", done, 0);
        chk("soft_busy", busy, 1);
        chk("soft_nrst1", nrst_out1, 0);
        tick();                                  // E0
        run_sequence("soft_seq");
        chk("soft_err", err, 0);

        // lock low for 100 cycles after reset
        rst  = 1'b1;
        lock = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("nolock_nrst", nrst_out, 0);
            chk("nolock_busy", busy, 1);
        end
        chk("nolock_err", err, ERR_STUCK);
        lock = 1'b1;
        tick();                                  // E0
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 15) chk("lock_pre", nrst_out, 0);
            if (k == 16) chk("lock_rel0", nrst_out, 4'b0001);
            if (k == 32) chk("lock_rel1", nrst_out, 4'b0011);
        end

        // lock drops at 0011
        lock = 1'b0;
        tick();
        chk("drop_nrst", nrst_out, 0);
        chk("drop_busy", busy, 1);
        chk("drop_done", done, 0);
        tick();
        tick();
        chk("drop_hold", nrst_out, 0);
        lock = 1'b1;
        tick();                                  // E0
        run_sequence("relock_seq");

        // soft_rst in DONE keeps err
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("soft2_nrst", nrst_out, 0);
        chk("soft2_err", err, ERR_STUCK);

        // rst mid-DELAY
        tick();                                  // E0
        for (int k = 1; k <= 20; k++) tick();
        chk("mid_nrst", nrst_out, 4'b0001);
        rst = 1'b1;
        tick();
        chk("midrst_nrst", nrst_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err",  err, 0);
        chk("midrst_nrst1", nrst_out1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
